// File: rtl/bit_rev_pkg.sv
// Shared definitions for the bit-reversal permutation engine.
//   ADDR_W_DEF / DATA_W_DEF : default address / sample widths
//   state_e                 : controller state encoding
//   bit_rev()               : reference bit reversal over the low w bits
package bit_rev_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 18;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_LATCH = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic [31:0] bit_rev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < w; k++) r[w-1-k] = v[k];
    return r;
  endfunction

endpackage

// File: rtl/bit_reverse.sv
// Combinational W-bit reverser: out_o[k] = in_i[W-1-k].
//   in_i  : index
//   out_o : bit-reversed index
module bit_reverse #(
  parameter int W = 10
) (
  input  logic [W-1:0] in_i,
  output logic [W-1:0] out_o
);

  for (genvar k = 0; k < W; k++) begin : g_bit
    assign out_o[k] = in_i[W-1-k];
  end

endmodule

// File: rtl/bit_rev_order.sv
// In-place bit-reversal permutation of a 2^ADDR_W-word memory held in an
// external true dual-port RAM (1-cycle synchronous read). For every i with
// i < rev(i) the pair is read together on ports A/B, then written back
// swapped. tc pulses for one cycle when the pass is complete.
//   Clk           : clock
//   reset         : async active-low reset
//   start         : begin a pass (sampled only in IDLE)
//   DinA / DinB   : RAM read data, valid the cycle after the address
//   write_enableA/B, addrA/B, DoutA/B : RAM write strobes, addresses, data
//   tc            : one-cycle completion pulse
module bit_rev_order
  import bit_rev_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] DinA,
  input  logic [DATA_W-1:0] DinB,
  output logic              write_enableA,
  output logic              write_enableB,
  output logic [ADDR_W-1:0] addrA,
  output logic [ADDR_W-1:0] addrB,
  output logic [DATA_W-1:0] DoutA,
  output logic [DATA_W-1:0] DoutB,
  output logic              tc
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] rev_d;
  logic [ADDR_W-1:0] addrA_q, addrA_d, addrB_q, addrB_d;
  logic [DATA_W-1:0] doutA_q, doutA_d, doutB_q, doutB_d;
  logic              we_q, we_d, tc_q, tc_d;

  // Reverse of the *next* index, so the address registers track the state
  // they are entering and every output stays registered.
  bit_reverse #(.W(ADDR_W)) u_rev (
    .in_i  (i_d),
    .out_o (rev_d)
  );

  // State register (outputs registered alongside)
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      addrA_q <= '0;
      addrB_q <= '0;
      doutA_q <= '0;
      doutB_q <= '0;
      we_q    <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      addrA_q <= addrA_d;
      addrB_q <= addrB_d;
      doutA_q <= doutA_d;
      doutB_q <= doutB_d;
      we_q    <= we_d;
      tc_q    <= tc_d;
    end
  end

  // Next-state logic. In SCAN, addrB_q already holds rev(i_q).
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_SCAN;
        i_d     = '0;
      end
      ST_SCAN: begin
        if (i_q < addrB_q)   state_d = ST_LATCH;
        else if (i_q == LAST) state_d = ST_DONE;
        else                  i_d = i_q + 1'b1;
      end
      ST_LATCH: state_d = ST_WRITE;
      ST_WRITE: begin
        if (i_q == LAST) state_d = ST_DONE;
        else begin
          state_d = ST_SCAN;
          i_d     = i_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: values for the state being entered. Data is cross-captured
  // at the end of LATCH so WRITE puts mem[rev(i)] at i and mem[i] at rev(i).
  always_comb begin
    logic busy;
    busy    = (state_d == ST_SCAN) || (state_d == ST_LATCH) || (state_d == ST_WRITE);
    addrA_d = busy ? i_d   : '0;
    addrB_d = busy ? rev_d : '0;
    we_d    = (state_d == ST_WRITE);
    tc_d    = (state_d == ST_DONE);
    doutA_d = (state_q == ST_LATCH) ? DinB : doutA_q;
    doutB_d = (state_q == ST_LATCH) ? DinA : doutB_q;
  end

  assign write_enableA = we_q;
  assign write_enableB = we_q;
  assign addrA         = addrA_q;
  assign addrB         = addrB_q;
  assign DoutA         = doutA_q;
  assign DoutB         = doutB_q;
  assign tc            = tc_q;

endmodule

// File: tb/tb_bit_rev_order.sv
module tb_bit_rev_order;

  localparam int AW = 10;
  localparam int DW = 18;
  localparam int N  = 1 << AW;

  logic          Clk, reset, start;
  logic [DW-1:0] DinA, DinB;
  logic          weA, weB, tc;
  logic [AW-1:0] addrA, addrB;
  logic [DW-1:0] DoutA, DoutB;

  // behavioural RAM / constant-data source
  logic [DW-1:0] mem [N];
  logic [DW-1:0] ramA, ramB, constA, constB;
  logic          use_ram, load_req;

  int n_cmp = 0;
  int n_err = 0;
  int wr_total = 0, tc_total = 0, same_addr = 0;

  bit_rev_order #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk(Clk), .reset(reset), .start(start), .DinA(DinA), .DinB(DinB),
    .write_enableA(weA), .write_enableB(weB), .addrA(addrA), .addrB(addrB),
    .DoutA(DoutA), .DoutB(DoutB), .tc(tc)
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  assign DinA = use_ram ? ramA : constA;
  assign DinB = use_ram ? ramB : constB;

  always @(posedge Clk) begin
    if (load_req) begin
      for (int k = 0; k < N; k++) mem[k] <= DW'(k);
    end else begin
      if (weA) mem[addrA] <= DoutA;
      if (weB) mem[addrB] <= DoutB;
    end
    ramA <= mem[addrA];
    ramB <= mem[addrB];
  end

  always @(posedge Clk) begin
    if (weA) wr_total <= wr_total + 1;
    if (tc) tc_total <= tc_total + 1;
    if (weA && weB && addrA == addrB) same_addr <= same_addr + 1;
  end

  function automatic int trev(input int v);
    int r = 0;
    for (int k = 0; k < AW; k++) if (v[k]) r |= (1 << (AW - 1 - k));
    return r;
  endfunction

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic load_identity;
    load_req = 1;
    tick();
    load_req = 0;
  endtask

  // ticks until tc; cyc = edges after the start-sampling edge
  task automatic run_to_tc(output int cyc, output bit ok);
    cyc = 0;
    ok  = 0;
    for (int t = 0; t < 3000; t++) begin
      tick();
      cyc++;
      if (tc) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic check_mem(input string nm, input bit want_rev);
    int bad = 0;
    for (int k = 0; k < N; k++)
      if (mem[k] !== DW'(want_rev ? trev(k) : k)) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s: %0d words wrong, want 0", nm, bad);
    end
  endtask

  // start, run to tc, check latency / writes / tc count / memory image
  task automatic full_pass(input string nm, input bit want_rev);
    int cyc, wb, tb0;
    bit ok;
    wb = wr_total;
    tb0 = tc_total;
    start = 1;
    tick();
    start = 0;
    run_to_tc(cyc, ok);
    n_cmp++;
    if (!ok || cyc != 2016) begin
      n_err++;
      $display("FAIL %s_latency: got %0d (tc seen %0d) want 2016", nm, cyc, ok);
    end
    repeat (3) tick();
    n_cmp++;
    if (wr_total - wb != 496) begin
      n_err++;
      $display("FAIL %s_writes: got %0d want 496", nm, wr_total - wb);
    end
    n_cmp++;
    if (tc_total - tb0 != 1) begin
      n_err++;
      $display("FAIL %s_tc_count: got %0d want 1", nm, tc_total - tb0);
    end
    check_mem({nm, "_mem"}, want_rev);
  endtask

  task automatic test_reset;
    int wb, tb0;
    reset = 0;
    #3;
    n_cmp++;
    if ({weA, weB, tc, addrA, addrB, DoutA, DoutB} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0",
               {weA, weB, tc, addrA, addrB, DoutA, DoutB});
    end
    tick();
    reset = 1;
    wb = wr_total;
    tb0 = tc_total;
    repeat (20) tick();
    n_cmp++;
    if (wr_total != wb || tc_total != tb0 || tc !== 1'b0) begin
      n_err++;
      $display("FAIL idle_quiet: writes %0d tc %0d want 0 0", wr_total - wb, tc_total - tb0);
    end
  endtask

  task automatic test_const_data;
    int t;
    use_ram = 0;
    constA = 5;
    constB = 10;
    start = 1;
    tick();
    start = 0;
    n_cmp++;
    if (addrA !== 0 || addrB !== 0 || weA !== 0) begin
      n_err++;
      $display("FAIL first_scan: addrA %0d addrB %0d we %0d want 0 0 0", addrA, addrB, weA);
    end
    t = 0;
    while (!weA && t < 10) begin
      tick();
      t++;
    end
    n_cmp++;
    if (weA !== 1 || weB !== 1 || addrA !== 1 || addrB !== 512 || DoutA !== 10 || DoutB !== 5) begin
      n_err++;
      $display("FAIL first_write: we %0d%0d addr %0d/%0d dout %0d/%0d want 11 1/512 10/5",
               weA, weB, addrA, addrB, DoutA, DoutB);
    end
    tick();
    n_cmp++;
    if (weA !== 0 || weB !== 0) begin
      n_err++;
      $display("FAIL write_one_cycle: we %0d%0d want 00", weA, weB);
    end
    reset = 0;
    tick();
    reset = 1;
    tick();
    use_ram = 1;
  endtask

  task automatic test_full_run;
    load_identity();
    full_pass("full", 1);
    n_cmp++;
    if (mem[0] !== 0 || mem[N-1] !== DW'(N-1) || mem[513] !== 513 || mem[1] !== 512 || mem[512] !== 1) begin
      n_err++;
      $display("FAIL spot_words: %0d %0d %0d %0d %0d want 0 1023 513 512 1",
               mem[0], mem[N-1], mem[513], mem[1], mem[512]);
    end
    n_cmp++;
    if (same_addr != 0) begin
      n_err++;
      $display("FAIL same_addr_write: got %0d want 0", same_addr);
    end
  endtask

  task automatic test_reset_mid;
    int nw, wb, tb0;
    load_identity();
    wb = wr_total;
    tb0 = tc_total;
    start = 1;
    tick();
    start = 0;
    nw = 0;
    for (int t = 0; t < 3000; t++) begin
      tick();
      if (weA) nw++;
      if (nw == 10) break;
    end
    reset = 0;
    #1;
    n_cmp++;
    if ({weA, weB, tc, addrA, addrB, DoutA, DoutB} !== '0) begin
      n_err++;
      $display("FAIL abort_outputs: got %h want 0", {weA, weB, tc, addrA, addrB, DoutA, DoutB});
    end
    tick();
    reset = 1;
    repeat (30) tick();
    n_cmp++;
    if (wr_total - wb != 9 || tc_total != tb0) begin
      n_err++;
      $display("FAIL abort_effect: writes %0d tc %0d want 9 0", wr_total - wb, tc_total - tb0);
    end
    load_identity();
    full_pass("after_abort", 1);
  endtask

  task automatic test_busy_start;
    int cyc, wb, tb0;
    bit ok;
    wb = wr_total;
    tb0 = tc_total;
    start = 1;
    tick();
    start = 0;
    cyc = 0;
    ok = 0;
    for (int t = 0; t < 3000; t++) begin
      start = (cyc % 100 == 50 && cyc < 1900);
      tick();
      cyc++;
      if (tc) begin
        ok = 1;
        break;
      end
    end
    start = 0;
    repeat (3) tick();
    n_cmp++;
    if (!ok || cyc != 2016 || tc_total - tb0 != 1 || wr_total - wb != 496) begin
      n_err++;
      $display("FAIL busy_start: cyc %0d tc %0d writes %0d want 2016 1 496",
               cyc, tc_total - tb0, wr_total - wb);
    end
    check_mem("busy_mem", 0);
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit ok;
    load_identity();
    start = 1;
    tick();
    run_to_tc(cyc, ok);
    n_cmp++;
    if (!ok || cyc != 2016) begin
      n_err++;
      $display("FAIL b2b_first: got %0d want 2016", cyc);
    end
    check_mem("b2b_first_mem", 1);
    tick();
    tick();
    start = 0;
    n_cmp++;
    if (addrA !== 0 || addrB !== 0 || weA !== 0) begin
      n_err++;
      $display("FAIL b2b_restart: addrA %0d addrB %0d we %0d want 0 0 0", addrA, addrB, weA);
    end
    run_to_tc(cyc, ok);
    n_cmp++;
    if (!ok || cyc != 2016) begin
      n_err++;
      $display("FAIL b2b_second: got %0d want 2016", cyc);
    end
    repeat (2) tick();
    check_mem("b2b_second_mem", 0);
  endtask

  initial begin
    start = 0;
    use_ram = 1;
    load_req = 0;
    constA = 0;
    constB = 0;
    test_reset();
    test_const_data();
    test_full_run();
    test_reset_mid();
    test_busy_start();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
